// File: rtl/dir_key_repeat.sv
// dir_key_repeat: turns four debounced direction key levels into single-cycle
// move requests, with an initial auto-repeat delay followed by a fixed repeat
// rate while the most recently pressed key stays held.
module dir_key_repeat #(
    parameter int unsigned CLK_PER_MS = 100000,
    parameter int unsigned DELAY_MS   = 250,
    parameter int unsigned REPEAT_MS  = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] keys,
    output logic       move_valid,
    output logic [1:0] move_dir,
    output logic       held
);

    localparam int unsigned PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2
    } state_e;

    // Input path: two-flop synchroniser plus previous-level register for edges.
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] s3;

    state_e          state;
    logic [1:0]      act;
    logic [PW-1:0]   pre_cnt;
    logic [9:0]      ms_cnt;

    logic [3:0]      new_press;
    logic            any_press;
    logic [1:0]      sel;
    logic            tick;
    logic [9:0]      ms_limit;
    logic            act_level;

    // Synchronise the key levels and keep the previous level for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 4'b0000;
            s2 <= 4'b0000;
            s3 <= 4'b0000;
        end else begin
            s1 <= keys;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Rising-edge detect with fixed priority: up > down > left > right.
    always_comb begin
        new_press = s2 & ~s3;
        any_press = |new_press;
        sel       = 2'd0;
        if (new_press[0]) begin
            sel = 2'd0;
        end else if (new_press[1]) begin
            sel = 2'd1;
        end else if (new_press[2]) begin
            sel = 2'd2;
        end else if (new_press[3]) begin
            sel = 2'd3;
        end
    end

    // Millisecond tick, per-state ms target and level of the tracked key.
    always_comb begin
        tick      = (pre_cnt == PW'(CLK_PER_MS - 1));
        ms_limit  = (state == StDelay) ? 10'(DELAY_MS - 1) : 10'(REPEAT_MS - 1);
        act_level = s2[act];
    end

    // Tracking FSM with registered outputs; a new press always restarts timing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= StIdle;
            act        <= 2'd0;
            pre_cnt    <= '0;
            ms_cnt     <= 10'd0;
            move_valid <= 1'b0;
            move_dir   <= 2'd0;
            held       <= 1'b0;
        end else begin
            move_valid <= 1'b0;
            unique case (state)
                StIdle: begin
                    pre_cnt <= '0;
                    ms_cnt  <= 10'd0;
                    if (any_press) begin
                        act        <= sel;
                        move_valid <= 1'b1;
                        move_dir   <= sel;
                        state      <= StDelay;
                        held       <= 1'b1;
                    end
                end
                StDelay, StRepeat: begin
                    if (any_press) begin
                        act        <= sel;
                        move_valid <= 1'b1;
                        move_dir   <= sel;
                        pre_cnt    <= '0;
                        ms_cnt     <= 10'd0;
                        state      <= StDelay;
                        held       <= 1'b1;
                    end else if (!act_level) begin
                        // Tracked key released: earlier keys still held never resume.
                        pre_cnt <= '0;
                        ms_cnt  <= 10'd0;
                        state   <= StIdle;
                        held    <= 1'b0;
                    end else if (tick) begin
                        pre_cnt <= '0;
                        if (ms_cnt == ms_limit) begin
                            move_valid <= 1'b1;
                            move_dir   <= act;
                            ms_cnt     <= 10'd0;
                            state      <= StRepeat;
                        end else begin
                            ms_cnt <= ms_cnt + 10'd1;
                        end
                    end else begin
                        pre_cnt <= pre_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= StIdle;
                    held    <= 1'b0;
                    pre_cnt <= '0;
                    ms_cnt  <= 10'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dir_key_repeat.sv
// tb_dir_key_repeat: table vectors, hand-written timing scenarios and random
// stimulus checked against a cycles-since-press reference model.
module tb_dir_key_repeat;

    localparam int unsigned CPM   = 4;
    localparam int unsigned DMS   = 3;
    localparam int unsigned RMS   = 2;
    localparam int          FIRST = DMS * CPM;
    localparam int          REP   = RMS * CPM;

    logic       clk;
    logic       rst_n;
    logic [3:0] keys;
    logic       move_valid;
    logic [1:0] move_dir;
    logic       held;

    dir_key_repeat #(
        .CLK_PER_MS(CPM),
        .DELAY_MS  (DMS),
        .REPEAT_MS (RMS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .keys      (keys),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .held      (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: key samples from the last three edges, plus the active
    // key and the number of cycles elapsed since its press pulse.
    logic [3:0] smp0, smp1, smp2;
    bit         m_trk;
    logic [1:0] m_act;
    logic [1:0] m_dir;
    bit         m_mv;
    int         m_t;

    int cyc_idx;
    int p_idx[$];
    int p_dir[$];
    int e_idx[$];
    int e_dir[$];

    typedef struct {
        logic       rst;
        logic [3:0] k;
        logic       mv;
        logic [1:0] dir;
        logic       hd;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] k, input logic r);
        logic [3:0] np;
        if (!r) begin
            smp0 = 4'b0; smp1 = 4'b0; smp2 = 4'b0;
            m_trk = 0; m_act = 2'd0; m_dir = 2'd0; m_mv = 0; m_t = 0;
        end else begin
            // A press is visible two edges after it is first sampled.
            np   = smp1 & ~smp2;
            m_mv = 0;
            if (np != 4'b0) begin
                for (int i = 3; i >= 0; i--) if (np[i]) m_act = 2'(i);
                m_trk = 1;
                m_t   = 0;
                m_mv  = 1;
                m_dir = m_act;
            end else if (m_trk) begin
                if (!smp1[m_act]) begin
                    m_trk = 0;
                end else begin
                    m_t++;
                    if (m_t == FIRST || (m_t > FIRST && (m_t - FIRST) % REP == 0)) begin
                        m_mv  = 1;
                        m_dir = m_act;
                    end
                end
            end
            smp2 = smp1;
            smp1 = smp0;
            smp0 = k;
        end
    endtask

    task automatic drive(input logic [3:0] k, input logic r);
        keys  = k;
        rst_n = r;
        @(posedge clk);
        model_step(k, r);
        #1;
        if (move_valid === 1'b1) begin
            p_idx.push_back(cyc_idx);
            p_dir.push_back(int'(move_dir));
        end
        cyc_idx++;
    endtask

    task automatic check_model();
        check("move_valid", int'(move_valid), int'(m_mv));
        check("move_dir", int'(move_dir), int'(m_dir));
        check("held", int'(held), int'(m_trk));
    endtask

    task automatic step(input logic [3:0] k, input logic r);
        drive(k, r);
        check_model();
    endtask

    task automatic start_scn();
        p_idx.delete(); p_dir.delete();
        e_idx.delete(); e_dir.delete();
        cyc_idx = 0;
    endtask

    task automatic expect_pulse(input int i, input int d);
        e_idx.push_back(i);
        e_dir.push_back(d);
    endtask

    task automatic check_pulses(input string name);
        int n;
        check({name, "_count"}, p_idx.size(), e_idx.size());
        n = (p_idx.size() < e_idx.size()) ? p_idx.size() : e_idx.size();
        for (int i = 0; i < n; i++) begin
            check({name, "_cycle"}, p_idx[i], e_idx[i]);
            check({name, "_dir"}, p_dir[i], e_dir[i]);
        end
    endtask

    task automatic idle_gap();
        repeat (6) step(4'b0000, 1'b1);
    endtask

    initial begin
        keys  = 4'b0000;
        rst_n = 1'b0;
        smp0 = 4'b0; smp1 = 4'b0; smp2 = 4'b0;
        m_trk = 0; m_act = 2'd0; m_dir = 2'd0; m_mv = 0; m_t = 0;
        cyc_idx = 0;

        // Reset for 5 cycles, then a 4-cycle left press and its release.
        for (int i = 0; i < 5; i++) vecs[i] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        vecs[5]  = '{1'b1, 4'b0100, 1'b0, 2'd0, 1'b0};
        vecs[6]  = '{1'b1, 4'b0100, 1'b0, 2'd0, 1'b0};
        vecs[7]  = '{1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
        vecs[8]  = '{1'b1, 4'b0100, 1'b0, 2'd2, 1'b1};
        vecs[9]  = '{1'b1, 4'b0000, 1'b0, 2'd2, 1'b1};
        vecs[10] = '{1'b1, 4'b0000, 1'b0, 2'd2, 1'b1};
        vecs[11] = '{1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].k, vecs[i].rst);
            check($sformatf("vec%0d_valid", i), int'(move_valid), int'(vecs[i].mv));
            check($sformatf("vec%0d_dir", i), int'(move_dir), int'(vecs[i].dir));
            check($sformatf("vec%0d_held", i), int'(held), int'(vecs[i].hd));
        end
        idle_gap();

        // Left held for 40 cycles: press pulse, first repeat +12, then every 8.
        start_scn();
        repeat (40) step(4'b0100, 1'b1);
        expect_pulse(2, 2); expect_pulse(14, 2); expect_pulse(22, 2);
        expect_pulse(30, 2); expect_pulse(38, 2);
        check_pulses("hold_left");
        idle_gap();

        // Short up press: one pulse only, held drops after the release.
        start_scn();
        repeat (8) step(4'b0001, 1'b1);
        repeat (8) step(4'b0000, 1'b1);
        expect_pulse(2, 0);
        check_pulses("short_up");
        check("short_up_held_end", int'(held), 0);

        // Down and right together: down wins; releasing down ends tracking.
        start_scn();
        repeat (6) step(4'b1010, 1'b1);
        repeat (10) step(4'b1000, 1'b1);
        expect_pulse(2, 1);
        check_pulses("dual_press");
        check("dual_press_held_end", int'(held), 0);
        idle_gap();

        // Up held, right added at T+10: right takes over, up repeat suppressed.
        start_scn();
        repeat (12) step(4'b0001, 1'b1);
        repeat (20) step(4'b1001, 1'b1);
        expect_pulse(2, 0); expect_pulse(14, 3); expect_pulse(26, 3);
        check_pulses("takeover");
        idle_gap();

        // Down held through a 2-cycle reset in REPEAT: fresh press afterwards.
        start_scn();
        repeat (24) step(4'b0010, 1'b1);
        repeat (2) step(4'b0010, 1'b0);
        check("reset_mid_valid", int'(move_valid), 0);
        check("reset_mid_held", int'(held), 0);
        repeat (19) step(4'b0010, 1'b1);
        expect_pulse(2, 1); expect_pulse(14, 1); expect_pulse(22, 1);
        expect_pulse(28, 1); expect_pulse(40, 1);
        check_pulses("reset_mid");
        idle_gap();

        // Random key activity with occasional resets.
        begin
            logic [3:0] rk;
            logic       rr;
            rk = 4'b0000;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 5) == 0) rk = 4'($urandom_range(0, 15));
                rr = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
                step(rk, rr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dir_key_repeat.md
Name: dir_key_repeat

Overview:
- Consumer of the debounced button levels: turns four held direction keys (up/down/left/right) into single-cycle Pacman move requests.
- Emits one move pulse on each press. If the key stays held, emits a further pulse after an initial delay, then repeats at a fixed rate.
- Sits between the per-button debouncers and the game-logic movement controller. Only the most recently pressed key is honoured.

Parameters:
- CLK_PER_MS, 100000, clk cycles per millisecond tick (100 MHz board clock).
- DELAY_MS, 250, ms from the first pulse to the first repeat pulse; legal range 1..1023.
- REPEAT_MS, 100, ms between subsequent repeat pulses; legal range 1..1023.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- keys  in  4  debounced levels, 1 = pressed; bit0 up, bit1 down, bit2 left, bit3 right. Asynchronous to clk (generated on the 1 ms domain).
- move_valid  out  1  single-cycle move request.
- move_dir  out  2  direction code for move_valid: 0 up, 1 down, 2 left, 3 right.
- held  out  1  high while a key is being tracked (state != IDLE).

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values:
  - move_valid=0, move_dir=0, held=0.
  - FSM=IDLE.
  - Sync stages and the previous-level register all 0.
  - Prescaler and ms counter 0.
- Input path: 2-flop synchroniser per bit (s1, s2), then a previous-level register s3. new_press[i] = s2[i] & ~s3[i].
- Latency: the first clk edge that samples keys[i]=1 is edge N. move_valid is high in the cycle after edge N+2.
- Press selection: when any new_press bits are set, the lowest index wins (up > down > left > right). Other simultaneous presses are discarded and never fire later.
- Tracking registers:
  - act[1:0]: the active key.
  - pre_cnt: counts 0..CLK_PER_MS-1; tick = (pre_cnt == CLK_PER_MS-1).
  - ms_cnt: 10 bits.
- FSM:
  - IDLE: on a new press, set act, pulse move_valid with move_dir=act, clear pre_cnt and ms_cnt, go to DELAY.
  - DELAY: pre_cnt runs. On each tick, if ms_cnt == DELAY_MS-1 then pulse, clear ms_cnt, go to REPEAT; else ms_cnt++.
  - REPEAT: on each tick, if ms_cnt == REPEAT_MS-1 then pulse and clear ms_cnt; else ms_cnt++.
  - DELAY or REPEAT, any new press (on any key, including act re-pressed): the same action as from IDLE. The new key takes over and its timing restarts. A new press takes priority over a timer pulse in the same cycle; exactly one pulse is emitted.
  - DELAY or REPEAT, s2[act]==0 and no new press: go to IDLE with no pulse. Keys still held from earlier presses do not resume.
- Resulting timing from the first pulse: the repeat pulse comes DELAY_MS*CLK_PER_MS cycles later, then one every REPEAT_MS*CLK_PER_MS cycles.
- move_valid is never high on two consecutive cycles, except when a new press immediately follows a pulse. move_dir holds its last value between pulses.
- pre_cnt runs only in DELAY/REPEAT; it is held at 0 in IDLE.
- Reset mid-operation: all state clears. A key held through reset is treated as a fresh press after rst_n rises, because s3 resets to 0. Its pulse comes 3 cycles after release, as above.
- A key released and re-pressed faster than the sync path (under 1 cycle) may be missed; this is acceptable given the debounced input.

Test Plan:
Use CLK_PER_MS=4, DELAY_MS=3, REPEAT_MS=2.
- Reset check: hold rst_n=0 for 5 cycles with keys=4'b0000 -> move_valid=0, held=0, move_dir=0 throughout.
- Hold keys=4'b0100 from edge N for 40 cycles -> pulses with move_dir=2 at edge N+2 (T), then T+12, T+20, T+28, T+36; held=1 from T.
- Press keys=4'b0001, release after 8 cycles -> exactly one pulse with move_dir=0; held returns to 0 within 3 cycles of the release reaching s2; no further pulses.
- keys=4'b1010 rising on the same edge -> a single pulse with move_dir=1. Release bit1 while bit3 is still held -> IDLE, no pulse for right.
- Hold up; at T+10 also press right -> a pulse with move_dir=3 when the press reaches s2. The up repeat due at T+12 does not occur. The next pulse is right, 12 cycles after its first pulse.
- Hold down, assert rst_n=0 for 2 cycles mid-REPEAT, then release reset -> outputs 0 during reset; a fresh move_dir=1 pulse 3 cycles after rst_n rises, then the repeat 12 cycles later.
